// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared types and the round-robin pick function for mux_rr_arbiter.
// Requests are carried padded to 16 bits (the largest legal channel count);
// padding bits are always zero, so a 16-wide wrap search is identical to a
// search that wraps at the real channel count.
package mux_arb_pkg;

  localparam int MAX_CH    = 16;
  localparam int MAX_SEL_W = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  typedef struct packed {
    logic                 found;
    logic [MAX_SEL_W-1:0] idx;
  } rr_pick_t;

  // First set request strictly after ptr, ascending with wrap; ptr itself is checked last.
  function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0] req,
                                       input logic [MAX_SEL_W-1:0] ptr);
    rr_pick_t             res;
    logic [MAX_SEL_W-1:0] idx;
    res.found = 1'b0;
    res.idx   = {MAX_SEL_W{1'b0}};
    for (int i = 1; i <= MAX_CH; i++) begin
      idx = ptr + i[MAX_SEL_W-1:0];
      if (!res.found && req[idx]) begin
        res.found = 1'b1;
        res.idx   = idx;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arb_core.sv
// rr_arb_core: combinational round-robin search over NUM_CH requests.
module rr_arb_core
  import mux_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic              found,
  output logic [SEL_W-1:0]  grant
);

  logic [MAX_CH-1:0]    req_pad_s;
  logic [MAX_SEL_W-1:0] ptr_pad_s;
  rr_pick_t             pick_s;

  // Widen request vector and pointer to the package's fixed search width, then search.
  always_comb begin
    req_pad_s               = {MAX_CH{1'b0}};
    req_pad_s[NUM_CH-1:0]   = req;
    ptr_pad_s               = {MAX_SEL_W{1'b0}};
    ptr_pad_s[SEL_W-1:0]    = ptr;
    pick_s                  = rr_pick(req_pad_s, ptr_pad_s);
  end

  // Narrow the picked index back to SEL_W by matching it against each legal channel.
  always_comb begin
    found = pick_s.found;
    grant = {SEL_W{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      if (pick_s.idx == MAX_SEL_W'(k)) begin
        grant = SEL_W'(k);
      end else begin
        grant = grant;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: NUM_CH-to-1 registered mux with round-robin arbitration and
// valid/ready flow control. Define MUX_ARB_LOCK_EN to add packet lock via i_Last.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic [NUM_CH-1:0]       i_Valid,
  input  logic [NUM_CH*WIDTH-1:0] i_Data,
`ifdef MUX_ARB_LOCK_EN
  input  logic [NUM_CH-1:0]       i_Last,
`endif
  output logic [NUM_CH-1:0]       o_Ready,
  output logic                    o_Valid,
  output logic [WIDTH-1:0]        o_Data,
  output logic [SEL_W-1:0]        o_Sel,
  input  logic                    i_Ready
);

  logic              valid_r;
  logic [WIDTH-1:0]  data_r;
  logic [SEL_W-1:0]  sel_r;
  logic [SEL_W-1:0]  ptr_r;

  logic              load_s;
  logic              found_s;
  logic [SEL_W-1:0]  pick_s;
  logic [SEL_W-1:0]  grant_s;
  logic              req_hit_s;
  logic              accept_s;
  logic [WIDTH-1:0]  data_sel_s;
  logic [NUM_CH-1:0] ready_s;

`ifdef MUX_ARB_LOCK_EN
  lock_state_t       state_r;
  lock_state_t       state_nxt_s;
  logic              valid_at_ptr_s;
  logic              last_sel_s;
`endif

  rr_arb_core #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_core (
    .req    (i_Valid),
    .ptr    (ptr_r),
    .found  (found_s),
    .grant  (pick_s)
  );

`ifdef MUX_ARB_LOCK_EN
  // Valid and end-of-packet flag of the locked channel / current grant.
  always_comb begin
    valid_at_ptr_s = 1'b0;
    last_sel_s     = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ptr_r == SEL_W'(k)) begin
        valid_at_ptr_s = i_Valid[k];
      end else begin
        valid_at_ptr_s = valid_at_ptr_s;
      end
      if (grant_s == SEL_W'(k)) begin
        last_sel_s = i_Last[k];
      end else begin
        last_sel_s = last_sel_s;
      end
    end
  end
`endif

  // Grant selection: round-robin pick, overridden by the held channel while locked.
  always_comb begin
    load_s    = !valid_r || i_Ready;
    grant_s   = pick_s;
    req_hit_s = found_s;
`ifdef MUX_ARB_LOCK_EN
    if (state_r == LOCKED) begin
      grant_s   = ptr_r;
      req_hit_s = valid_at_ptr_s;
    end else begin
      grant_s   = pick_s;
      req_hit_s = found_s;
    end
`endif
    accept_s  = i_Rst_L && load_s && req_hit_s;
  end

  // One-hot ready to the granted channel and its data word for the output register.
  always_comb begin
    ready_s    = {NUM_CH{1'b0}};
    data_sel_s = {WIDTH{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant_s == SEL_W'(k)) begin
        ready_s[k] = accept_s;
        data_sel_s = i_Data[k*WIDTH +: WIDTH];
      end else begin
        ready_s[k] = 1'b0;
      end
    end
  end

  // Output register and round-robin pointer; a drain and a fill can share one edge.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      valid_r <= 1'b0;
      data_r  <= {WIDTH{1'b0}};
      sel_r   <= {SEL_W{1'b0}};
      ptr_r   <= SEL_W'(NUM_CH - 1);
    end else if (accept_s) begin
      valid_r <= 1'b1;
      data_r  <= data_sel_s;
      sel_r   <= grant_s;
      ptr_r   <= grant_s;
    end else if (load_s) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

`ifdef MUX_ARB_LOCK_EN
  // Lock state register.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Lock next state: enter on a non-last beat, leave on the locked channel's last beat.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && !last_sel_s) state_nxt_s = LOCKED;
        else                         state_nxt_s = IDLE;
      end
      LOCKED: begin
        if (accept_s && last_sel_s) state_nxt_s = IDLE;
        else                        state_nxt_s = LOCKED;
      end
      default: state_nxt_s = IDLE;
    endcase
  end
`endif

  assign o_Ready = ready_s;
  assign o_Valid = valid_r;
  assign o_Data  = data_r;
  assign o_Sel   = sel_r;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Testbench for mux_rr_arbiter (NUM_CH=4, WIDTH=8) against a behavioural model.
module tb_mux_rr_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   i_valid = '0;
  logic [N*W-1:0] i_data;
  logic [N-1:0]   o_ready;
  logic           o_valid;
  logic [W-1:0]   o_data;
  logic [1:0]     o_sel;
  logic           i_ready = 1'b0;
  logic [N-1:0]   i_last = '0;
  logic [W-1:0]   chan_data [N];

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  int         m_ptr, m_sel, m_g;
  bit         m_valid, m_load, m_found, m_accept, m_locked;
  logic [W-1:0] m_data;
  logic [N-1:0] exp_ready;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < N; k++) i_data[k*W +: W] = chan_data[k];
  end

  mux_rr_arbiter #(.NUM_CH(N), .WIDTH(W)) dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .i_Valid (i_valid),
    .i_Data  (i_data),
`ifdef MUX_ARB_LOCK_EN
    .i_Last  (i_last),
`endif
    .o_Ready (o_ready),
    .o_Valid (o_valid),
    .o_Data  (o_data),
    .o_Sel   (o_sel),
    .i_Ready (i_ready)
  );

  task automatic model_reset();
    m_ptr = N - 1; m_sel = 0; m_valid = 0; m_data = '0; m_locked = 0;
  endtask

  // Expected grant from the rules: first requester after the last grant, wrapping.
  task automatic model_comb();
    int c;
    m_load  = !m_valid || i_ready;
    m_found = 0;
    m_g     = 0;
    if (m_locked) begin
      m_found = i_valid[m_ptr];
      m_g     = m_ptr;
    end else begin
      for (int d = 1; d <= N; d++) begin
        c = (m_ptr + d) % N;
        if (!m_found && i_valid[c]) begin
          m_found = 1; m_g = c;
        end
      end
    end
    m_accept  = rst_n && m_load && m_found;
    exp_ready = m_accept ? (4'b0001 << m_g) : 4'b0000;
  endtask

  // Advance one clock; the model takes the same transition, outputs sampled 1ns after the edge.
  task automatic tick();
    model_comb();
    @(posedge clk);
    if (rst_n) begin
      if (m_accept) begin
        m_valid = 1; m_sel = m_g; m_data = chan_data[m_g]; m_ptr = m_g;
`ifdef MUX_ARB_LOCK_EN
        if (!m_locked && !i_last[m_g]) m_locked = 1;
        else if (m_locked && i_last[m_g]) m_locked = 0;
`endif
      end else if (m_load) begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_valid = 4'b1111; i_ready = 1'b1;
    model_reset();
    #3;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", o_valid); end
    n_checks++; if (o_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", o_data); end
    n_checks++; if (o_sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel got %0d want 0", o_sel); end
    n_checks++; if (o_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got %b want 0000", o_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    i_valid = 4'b0000;
    #1;
  endtask

  task automatic test_all_valid();
    chan_data[0] = 8'hA0; chan_data[1] = 8'hB1; chan_data[2] = 8'hC2; chan_data[3] = 8'hD3;
    i_valid = 4'b1111; i_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1; model_comb();
      n_checks++; if (o_ready !== (4'b0001 << (k % 4))) begin n_fail++; $display("FAIL rr_ready beat %0d got %b want %b", k, o_ready, 4'b0001 << (k % 4)); end
      tick();
      n_checks++; if (o_sel !== 2'(k % 4) || o_valid !== 1'b1) begin n_fail++; $display("FAIL rr_sel beat %0d got %0d/%b want %0d/1", k, o_sel, o_valid, k % 4); end
      n_checks++; if (o_data !== chan_data[k % 4]) begin n_fail++; $display("FAIL rr_data beat %0d got %h want %h", k, o_data, chan_data[k % 4]); end
    end
  endtask

  task automatic test_single_then_pair();
    i_valid = 4'b0100; i_ready = 1'b1;
    tick();
    n_checks++; if (o_sel !== 2'd2 || o_data !== 8'hC2) begin n_fail++; $display("FAIL single_ch2 got sel %0d data %h want 2 C2", o_sel, o_data); end
    i_valid = 4'b0101;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_checks++; if (o_sel !== ((k % 2 == 0) ? 2'd0 : 2'd2)) begin n_fail++; $display("FAIL pair_alt beat %0d got %0d want %0d", k, o_sel, (k % 2 == 0) ? 0 : 2); end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held_d;
    logic [1:0]   held_s;
    i_valid = 4'b1111; i_ready = 1'b1;
    tick();
    held_d = o_data; held_s = o_sel;
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (o_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready cyc %0d got %b want 0000", k, o_ready); end
      tick();
      n_checks++; if (o_data !== held_d || o_sel !== held_s || o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold cyc %0d got %h/%0d want %h/%0d", k, o_data, o_sel, held_d, held_s); end
    end
    i_ready = 1'b1;
    #1;
    n_checks++; if (o_ready !== (4'b0001 << ((held_s + 1) % 4))) begin n_fail++; $display("FAIL bp_release_ready got %b want %b", o_ready, 4'b0001 << ((held_s + 1) % 4)); end
    tick();
    n_checks++; if (o_sel !== 2'((held_s + 1) % 4) || o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_release_sel got %0d want %0d", o_sel, (held_s + 1) % 4); end
  endtask

  task automatic test_wrap();
    i_valid = 4'b1000; i_ready = 1'b1;
    tick();
    n_checks++; if (o_sel !== 2'd3) begin n_fail++; $display("FAIL wrap_setup got %0d want 3", o_sel); end
    i_valid = 4'b1001;
    tick();
    n_checks++; if (o_sel !== 2'd0 || o_data !== 8'hA0) begin n_fail++; $display("FAIL wrap_grant got %0d/%h want 0/A0", o_sel, o_data); end
    i_valid = 4'b0000;
    tick();
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL idle_drain got %b want 0", o_valid); end
  endtask

  task automatic test_async_reset();
    i_valid = 4'b1111; i_ready = 1'b1;
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++; if (o_valid !== 1'b0 || o_data !== 8'h00 || o_sel !== 2'd0) begin n_fail++; $display("FAIL async_rst got %b/%h/%0d want 0/00/0", o_valid, o_data, o_sel); end
    n_checks++; if (o_ready !== 4'b0000) begin n_fail++; $display("FAIL async_rst_ready got %b want 0000", o_ready); end
    tick();
    #2;
    rst_n = 1'b1;
    #1;
    n_checks++; if (o_ready !== 4'b0001) begin n_fail++; $display("FAIL post_rst_ready got %b want 0001", o_ready); end
    tick();
    n_checks++; if (o_sel !== 2'd0 || o_valid !== 1'b1) begin n_fail++; $display("FAIL post_rst_sel got %0d want 0", o_sel); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      i_valid = 4'($urandom_range(0, 15));
      i_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < N; c++) chan_data[c] = 8'($urandom);
      i_last = 4'($urandom_range(0, 15));
      #1; model_comb();
      n_checks++; if (o_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready cyc %0d got %b want %b", k, o_ready, exp_ready); end
      tick();
      n_checks++; if (o_valid !== m_valid || o_sel !== 2'(m_sel) || o_data !== m_data) begin n_fail++; $display("FAIL rand_out cyc %0d got %b/%0d/%h want %b/%0d/%h", k, o_valid, o_sel, o_data, m_valid, m_sel, m_data); end
    end
    i_last = '0;
  endtask

`ifdef MUX_ARB_LOCK_EN
  task automatic test_lock();
    logic [3:0] vtab [6];
    logic [3:0] ltab [6];
    int         stab [6];
    vtab = '{4'b0110, 4'b0100, 4'b0100, 4'b0110, 4'b0110, 4'b0100};
    ltab = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
    stab = '{1, -1, -1, 1, 1, 2};
    rst_n = 1'b0; i_valid = '0; i_ready = 1'b1;
    model_reset();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      i_valid = vtab[k]; i_last = ltab[k];
      for (int c = 0; c < N; c++) chan_data[c] = 8'($urandom);
      #1; model_comb();
      n_checks++; if (o_ready !== exp_ready) begin n_fail++; $display("FAIL lock_ready cyc %0d got %b want %b", k, o_ready, exp_ready); end
      tick();
      if (stab[k] >= 0) begin
        n_checks++; if (o_valid !== 1'b1 || o_sel !== 2'(stab[k])) begin n_fail++; $display("FAIL lock_sel cyc %0d got %b/%0d want 1/%0d", k, o_valid, o_sel, stab[k]); end
      end else begin
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL lock_stall cyc %0d got valid %b want 0", k, o_valid); end
      end
    end
    i_last = '0;
  endtask
`endif

  initial begin
    model_reset();
    for (int c = 0; c < N; c++) chan_data[c] = '0;
    test_reset();
    test_all_valid();
    test_single_then_pair();
    test_backpressure();
    test_wrap();
    test_async_reset();
`ifdef MUX_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Parametrised N-channel registered multiplexer with round-robin arbitration and valid/ready flow control. It is the next generation of the team's 4-to-1 select mux: the selection is arbitrated internally from requests rather than driven externally, and the result is registered. It sits between several producer streams and one consumer stream, and reports which channel each output beat came from.

## Interface
- NUM_CH, 4: number of input channels; legal values are 2..16.
- WIDTH, 8: data width per channel.
- SEL_W, $clog2(NUM_CH): derived width of the channel index; not overridden.

- i_Clk  in  1  clock; all state updates on the rising edge.
- i_Rst_L  in  1  reset, asynchronous assert, active low.
- i_Valid  in  NUM_CH  bit k = channel k presents a beat.
- i_Data  in  NUM_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- o_Ready  out  NUM_CH  bit k = channel k's beat is accepted this cycle.
- o_Valid  out  1  output register holds a beat.
- o_Data  out  WIDTH  registered data.
- o_Sel  out  SEL_W  index of the channel that produced o_Data.
- i_Ready  in  1  consumer accepts the beat.
- i_Last  in  NUM_CH  end-of-packet flag per channel; present only when MUX_ARB_LOCK_EN is defined.

## Operation
- Output stage is a one-entry register. load = !o_Valid || i_Ready.
- Arbitration is combinational each cycle. Search i_Valid starting at index (r_Ptr+1) mod NUM_CH, ascending with wrap. The first set bit is the grant g.
- o_Ready = onehot(g) when load and any i_Valid is set; otherwise all zero. At most one bit of o_Ready is ever set.
- When a beat is accepted (i_Valid[g] && o_Ready[g]):
  - o_Data <= channel g's data.
  - o_Sel <= g.
  - o_Valid <= 1.
  - r_Ptr <= g.
- When load is set and no beat is accepted, o_Valid <= 0.
- When i_Ready=0 and o_Valid=1, the output register holds its value: o_Data and o_Sel stay stable, and all o_Ready bits are 0.
- r_Ptr resets to NUM_CH-1, so after reset channel 0 has first priority.
- A producer keeps i_Valid and its data stable until it is accepted. The block does not require this, but it only samples data on acceptance.
- Fairness: a continuously requesting channel waits at most NUM_CH-1 accepted beats between its grants.

## Timing
- Reset values: o_Valid=0, o_Data=0, o_Sel=0, o_Ready=0, r_Ptr=NUM_CH-1. With the lock feature compiled in, state=IDLE.
- Latency: a beat accepted on edge n is visible on o_Data/o_Valid after edge n.
- Throughput: one beat per cycle while i_Ready=1. This holds because load depends combinationally on i_Ready.
- Simultaneous drain and fill: when o_Valid=1 and i_Ready=1, the old beat leaves and the new beat loads on the same edge, with no bubble.
- Index wrap: the search proceeds NUM_CH-1 → 0 with no skipped index.
- Reset asserted mid-transfer: all outputs go to their reset values immediately. Any in-flight beat is dropped and any lock is released.
- No requests: o_Ready=0, and o_Valid clears after the consumer drains the held beat.

## Configuration
- MUX_ARB_LOCK_EN defined: packet lock, using the i_Last port.
  - The state machine has two states, IDLE and LOCKED.
  - IDLE → LOCKED when a beat is accepted with i_Last[g]=0. The locked channel is recorded as r_Ptr.
  - In LOCKED the grant is forced to r_Ptr. Other channels receive no o_Ready even if the locked channel deasserts valid.
  - LOCKED → IDLE when a beat from the locked channel is accepted with i_Last=1.
  - A single-beat packet (i_Last=1 on its first beat) never enters LOCKED.
- MUX_ARB_LOCK_EN undefined: the i_Last port and the state machine are absent, and every beat is arbitrated independently.

## Structure
- Package mux_arb_pkg holds:
  - the function rr_pick(req, ptr), which returns the grant index and a found flag;
  - the typedef of the lock-state enum (IDLE, LOCKED).
- Sub-module rr_arb_core contains the combinational round-robin search over NUM_CH requests. The top level instantiates it once, alongside the output register, r_Ptr and the lock FSM.

## Test plan
- Reset, then a constant i_Ready=1 with i_Valid=4'b1111 and data A0,B1,C2,D3 → o_Sel sequence 0,1,2,3,0…, o_Data matching, one beat per cycle.
- i_Valid=4'b0100 only → o_Sel=2 after 1 cycle. Then add channel 0 → grants alternate 0,2,0,2…
- Backpressure: i_Ready=0 for 3 cycles with o_Valid=1 → o_Data/o_Sel stable, o_Ready=0000. On release the held beat drains and the next beat loads on the same edge.
- Wrap: r_Ptr=3 with i_Valid=4'b1001 → grant 0, not 3.
- Asynchronous reset asserted mid-stream between edges → o_Valid falls immediately. After release, channel 0 is granted first.
- MUX_ARB_LOCK_EN build: channel 1 sends a 3-beat packet (i_Last on beat 3) while channel 2 requests → o_Sel 1,1,1,2. Channel 1 stalling for 2 cycles mid-packet → channel 2 is still not granted.
